// File: rtl/serial_adder_pkg.sv
// Shared constants and FSM encoding for the bit-serial adder.
package serial_adder_pkg;

    localparam int DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : serial_adder_pkg

// File: rtl/serial_adder_full_adder1.sv
// 1-bit full-adder cell used as the serial adder's entire datapath.
module full_adder1 (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));

endmodule : full_adder1

// File: rtl/serial_adder.sv
// Bit-serial adder: one bit per cycle, LSB first, result qualified by a one-cycle done pulse.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic [1:0]       dbg_state
);

    // Handshake: start is accepted on a rising edge only when the FSM is in
    // IDLE or DONE; done is a single-cycle strobe qualifying sum/cout/ovf.

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              carry_q, carry_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;
    logic              busy_q, done_q;
    logic              fa_s, fa_co;

    full_adder1 u_fa (
        .x  (a_q[0]),
        .y  (b_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    state_d = RUN;
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                sum_d   = {fa_s, sum_q[WIDTH-1:1]};
                carry_d = fa_co;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    state_d = DONE;
                    cout_d  = fa_co;
                    // carry_q is the carry into the MSB on this final bit
                    ovf_d   = carry_q ^ fa_co;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            busy_q  <= (state_d == RUN);
            done_q  <= (state_d == DONE);
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign dbg_state = state_q;

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder at WIDTH=8.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic [1:0]   dbg_state;

    int vectors;
    int miscompares;

    serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Checks busy over the W run cycles; caller is in the first run cycle.
    task automatic expect_run(input string tag);
        for (int i = 0; i < W; i++) begin
            check({tag, "_busy"}, 64'(busy), 64'd1);
            check({tag, "_nodone"}, 64'(done), 64'd0);
            step();
        end
    endtask

    task automatic expect_result(input string tag, input logic [W-1:0] es,
                                 input logic ec, input logic eo);
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_busy_low"}, 64'(busy), 64'd0);
        check({tag, "_sum"}, 64'(sum), 64'(es));
        check({tag, "_cout"}, 64'(cout), 64'(ec));
        check({tag, "_ovf"}, 64'(ovf), 64'(eo));
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] oa, input logic [W-1:0] ob,
                          input logic oc, input logic [W-1:0] es, input logic ec, input logic eo);
        start = 1'b1;
        a     = oa;
        b     = ob;
        cin   = oc;
        step();
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        expect_run(tag);
        expect_result(tag, es, ec, eo);
        step();
        check({tag, "_pulse_end"}, 64'(done), 64'd0);
        check({tag, "_idle"}, 64'(dbg_state), 64'd0);
        // outputs hold after done
        check({tag, "_sum_hold"}, 64'(sum), 64'(es));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        #12;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_sum", 64'(sum), 64'd0);
        check("rst_cout", 64'(cout), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        check("rst_state", 64'(dbg_state), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        step();

        run_op("add_35_4a", 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0);
        run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        run_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        run_op("add_80_80_c", 8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 1'b1);

        // start reasserted with other operands during run cycles 3-5
        start = 1'b1; a = 8'h35; b = 8'h4A; cin = 1'b0;
        step();
        start = 1'b0;
        for (int i = 1; i <= W; i++) begin
            if (i >= 3 && i <= 5) begin
                start = 1'b1; a = 8'h11; b = 8'h22;
            end else begin
                start = 1'b0; a = '0; b = '0;
            end
            check("ign_busy", 64'(busy), 64'd1);
            check("ign_nodone", 64'(done), 64'd0);
            step();
        end
        start = 1'b0;
        expect_result("ign", 8'h7F, 1'b0, 1'b0);
        step();
        check("ign_single_done", 64'(done), 64'd0);
        check("ign_idle", 64'(busy), 64'd0);

        // reset in run cycle 4
        start = 1'b1; a = 8'h35; b = 8'h4A; cin = 1'b0;
        step();
        start = 1'b0;
        step();
        step();
        step();
        check("abort_busy_pre", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_sum", 64'(sum), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_state", 64'(dbg_state), 64'd0);
        step();
        rst = 1'b0;
        check("abort_no_done", 64'(done), 64'd0);
        run_op("post_rst", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);

        // start held high: back-to-back results every W+1 cycles
        start = 1'b1; a = 8'h10; b = 8'h01; cin = 1'b0;
        step();
        for (int r = 0; r < 3; r++) begin
            expect_run("b2b");
            expect_result("b2b", 8'h11, 1'b0, 1'b0);
            step();
        end
        start = 1'b0;
        for (int i = 1; i < W; i++) step();
        check("b2b_last_busy", 64'(busy), 64'd1);
        step();
        expect_result("b2b_last", 8'h11, 1'b0, 1'b0);
        step();
        check("b2b_end", 64'(done), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_serial_adder
